// File: rtl/register_file_mp.sv
// Multi-port register file with write-to-read bypass and a busy scoreboard.
// Two writeback lanes (lane 1 wins on conflict), NUM_RD combinational reads.
module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_dest,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     any_busy
);

    localparam logic ZR = (ZERO_REG != 0);
    localparam logic BP = (BYPASS != 0);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic              wr0_ok, wr1_ok, iss_ok;

    assign wr0_ok = wr0_en && !(ZR && wr0_addr == '0);
    assign wr1_ok = wr1_en && !(ZR && wr1_addr == '0);
    assign iss_ok = issue_en && !(ZR && issue_dest == '0);

    // Lane 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) regs_q[k] <= '0;
        end else begin
            if (wr0_ok) regs_q[wr0_addr] <= wr0_data;
            if (wr1_ok) regs_q[wr1_addr] <= wr1_data;
        end
    end

    // Issue applied after the clears: the newer producer keeps the reg busy.
    always_comb begin
        busy_d = busy_q;
        if (wr0_en) busy_d[wr0_addr] = 1'b0;
        if (wr1_en) busy_d[wr1_addr] = 1'b0;
        if (iss_ok) busy_d[issue_dest] = 1'b1;
        if (ZR) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign any_busy = |busy_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              b;

        assign a = rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            d = regs_q[a];
            b = busy_q[a];
            if (BP && wr1_en && wr1_addr == a) begin
                d = wr1_data;
                b = 1'b0;
            end else if (BP && wr0_en && wr0_addr == a) begin
                d = wr0_data;
                b = 1'b0;
            end
            if ((ZR && a == '0) || reset) begin
                d = '0;
                b = 1'b0;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = d;
        assign rd_busy[i] = b;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Randomised bench for register_file_mp against an array-based model.
// Runs a bypassing and a non-bypassing instance on the same stimulus.
module tb_register_file_mp;

    localparam int DW = 32;
    localparam int D  = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr0_en, wr1_en, issue_en;
    logic [AW-1:0] wr0_addr, wr1_addr, issue_dest;
    logic [DW-1:0] wr0_data, wr1_data;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data_b, rd_data_n;
    logic [NR-1:0]    rd_busy_b, rd_busy_n;
    logic             any_b, any_n;

    always #5 clk = ~clk;

    register_file_mp #(.BYPASS(1)) u_byp (
        .clk(clk), .reset(reset),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .issue_en(issue_en), .issue_dest(issue_dest),
        .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .any_busy(any_b)
    );

    register_file_mp #(.BYPASS(0)) u_nob (
        .clk(clk), .reset(reset),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .issue_en(issue_en), .issue_dest(issue_dest),
        .rd_addr(rd_addr), .rd_data(rd_data_n),
        .rd_busy(rd_busy_n), .any_busy(any_n)
    );

    logic [DW-1:0] mem [D];
    bit            bsy [D];
    int            errs = 0;
    int            checks = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input int a, input bit byp);
        if (a == 0) return '0;
        if (byp && wr1_en && int'(wr1_addr) == a) return wr1_data;
        if (byp && wr0_en && int'(wr0_addr) == a) return wr0_data;
        return mem[a];
    endfunction

    function automatic bit exp_busy(input int a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && wr1_en && int'(wr1_addr) == a) return 1'b0;
        if (byp && wr0_en && int'(wr0_addr) == a) return 1'b0;
        return bsy[a];
    endfunction

    function automatic bit exp_any();
        for (int k = 0; k < D; k++) if (bsy[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < D; k++) begin
            mem[k] = '0;
            bsy[k] = 1'b0;
        end
    endtask

    task automatic idle();
        wr0_en = 0; wr1_en = 0; issue_en = 0;
        wr0_addr = '0; wr1_addr = '0; issue_dest = '0;
        wr0_data = '0; wr1_data = '0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr[0*AW +: AW] = AW'(a0);
        rd_addr[1*AW +: AW] = AW'(a1);
    endtask

    task automatic check_all();
        for (int p = 0; p < NR; p++) begin
            int a;
            a = int'(rd_addr[p*AW +: AW]);
            chk("rd_data_byp", 64'(rd_data_b[p*DW +: DW]), 64'(exp_data(a, 1)));
            chk("rd_data_nob", 64'(rd_data_n[p*DW +: DW]), 64'(exp_data(a, 0)));
            chk("rd_busy_byp", 64'(rd_busy_b[p]), 64'(exp_busy(a, 1)));
            chk("rd_busy_nob", 64'(rd_busy_n[p]), 64'(exp_busy(a, 0)));
        end
        chk("any_byp", 64'(any_b), 64'(exp_any()));
        chk("any_nob", 64'(any_n), 64'(exp_any()));
    endtask

    // Checks the current inputs, then advances model and DUT by one edge.
    task automatic step();
        #2 check_all();
        if (wr0_en && wr0_addr != 0) mem[wr0_addr] = wr0_data;
        if (wr1_en && wr1_addr != 0) mem[wr1_addr] = wr1_data;
        if (wr0_en) bsy[wr0_addr] = 1'b0;
        if (wr1_en) bsy[wr1_addr] = 1'b0;
        if (issue_en && issue_dest != 0) bsy[issue_dest] = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        set_rd(5, 0);
        model_clear();
        repeat (2) @(negedge clk);
        #1 chk("rst_data", 64'(rd_data_b), 64'h0);
        chk("rst_any", 64'(any_b), 64'h0);
        reset = 1'b0;

        // Dual write to one reg: lane 1 wins, also when forwarded.
        wr0_en = 1; wr0_addr = 3; wr0_data = 32'h11;
        wr1_en = 1; wr1_addr = 3; wr1_data = 32'h22;
        set_rd(3, 3);
        #1 chk("t2_bypass", 64'(rd_data_b[DW-1:0]), 64'h22);
        step();
        idle();
        #1 chk("t2_stored", 64'(rd_data_n[DW-1:0]), 64'h22);
        step();

        // Without bypass, new data shows only after the edge.
        wr0_en = 1; wr0_addr = 7; wr0_data = 32'h55;
        set_rd(7, 7);
        #1 chk("t3_old", 64'(rd_data_n[DW-1:0]), 64'h0);
        step();
        idle();
        #1 chk("t3_new", 64'(rd_data_n[DW-1:0]), 64'h55);
        step();

        // Register 0 ignores writes and issue.
        wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFF_FFFF;
        issue_en = 1; issue_dest = 0;
        set_rd(0, 0);
        #1 chk("t4_r0", 64'(rd_data_b[DW-1:0]), 64'h0);
        chk("t4_busy", 64'(rd_busy_b[0]), 64'h0);
        step();
        idle();
        #1 chk("t4_any", 64'(any_b), 64'h0);
        step();

        // Scoreboard set by issue, cleared and masked by a write.
        issue_en = 1; issue_dest = 9;
        set_rd(9, 9);
        step();
        idle();
        #1 chk("t5_busy", 64'(rd_busy_b[0]), 64'h1);
        chk("t5_any", 64'(any_b), 64'h1);
        step();
        wr0_en = 1; wr0_addr = 9; wr0_data = 32'h9;
        #1 chk("t5_fwd", 64'(rd_data_b[DW-1:0]), 64'h9);
        chk("t5_mask", 64'(rd_busy_b[0]), 64'h0);
        chk("t5_nomask", 64'(rd_busy_n[0]), 64'h1);
        step();
        idle();
        #1 chk("t5_clr", 64'(rd_busy_n[0]), 64'h0);
        step();

        // Issue and write to the same reg: data lands, busy stays set.
        issue_en = 1; issue_dest = 4;
        wr1_en = 1; wr1_addr = 4; wr1_data = 32'h44;
        set_rd(4, 4);
        step();
        idle();
        #1 chk("t6_data", 64'(rd_data_n[DW-1:0]), 64'h44);
        chk("t6_busy", 64'(rd_busy_n[0]), 64'h1);
        step();

        // Asynchronous reset mid-run.
        wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEAD_BEEF;
        set_rd(5, 4);
        step();
        idle();
        #1 chk("t1_pre", 64'(rd_data_n[DW-1:0]), 64'hDEAD_BEEF);
        #1 reset = 1'b1;
        #1 chk("t1_data", 64'(rd_data_b), 64'h0);
        chk("t1_busy", 64'(rd_busy_b), 64'h0);
        chk("t1_any", 64'(any_n), 64'h0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        #1 chk("t1_after", 64'(rd_data_n[DW-1:0]), 64'h0);
        step();

        for (int n = 0; n < 400; n++) begin
            bit wide;
            wide = ($urandom_range(0, 3) == 0);
            wr0_en = 1'($urandom);
            wr1_en = ($urandom_range(0, 2) == 0);
            issue_en = ($urandom_range(0, 1) == 0);
            wr0_addr = AW'(wide ? $urandom : $urandom_range(0, 7));
            wr1_addr = AW'(wide ? $urandom : $urandom_range(0, 7));
            issue_dest = AW'(wide ? $urandom : $urandom_range(0, 7));
            wr0_data = $urandom;
            wr1_data = $urandom;
            set_rd(wide ? $urandom_range(0, 31) : $urandom_range(0, 7),
                   wide ? $urandom_range(0, 31) : $urandom_range(0, 7));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
